// File: rtl/a2d_spi_resp_pkg.sv
// Shared types and frame geometry for the A2D SPI responder.
package a2d_pkg;
  localparam int FRM_W   = 16;
  localparam int RES     = 12;
  localparam int NUM_CH  = 8;
  localparam int CH_LSB  = 11;
  localparam int CH_MSB  = 13;
  localparam int CNT_W   = 5;
  localparam int CH_W    = CH_MSB - CH_LSB + 1;

  typedef enum logic [1:0] {IDLE, SHIFT} resp_st_t;
endpackage

// File: rtl/a2d_spi_resp_spi_in_synch.sv
// Two-flop synchronizer plus one history flop for edge detection of an async input.
module spi_in_synch #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);
  logic [2:0] sync_q;

  // Reset to the idle level so release of reset never looks like an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= {3{RST_VAL}};
    else        sync_q <= {sync_q[1:0], d_i};
  end

  assign level_o = sync_q[1];
  assign rise_o  = sync_q[1] & ~sync_q[2];
  assign fall_o  = ~sync_q[1] & sync_q[2];
endmodule

// File: rtl/a2d_spi_resp.sv
// SPI mode-0 responder emulating an 8-channel 12-bit A2D with pipelined channel select.
module a2d_spi_resp
  import a2d_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    SS_n,
  input  logic                    SCLK,
  input  logic                    MOSI,
  output logic                    MISO,
  input  logic [NUM_CH*RES-1:0]   ch_data,
  output logic [CH_W-1:0]         chnl,
  output logic [FRM_W-1:0]        cmd,
  output logic                    cmd_vld,
  output logic                    frm_err
);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRM_W);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(FRM_W + 1);

  logic ss_lvl, ss_rise, ss_fall;
  logic sclk_lvl, sclk_rise, sclk_fall;
  logic [1:0] mosi_sync_q;
  logic mosi_s;

  resp_st_t          state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [FRM_W-1:0]  rx_q, rx_d, tx_q, tx_d, cmd_q, cmd_d;
  logic [CH_W-1:0]   chnl_q, chnl_d;
  logic              cmd_vld_q, cmd_vld_d, frm_err_q, frm_err_d;
  logic [RES-1:0]    ch_sel;

  spi_in_synch #(.RST_VAL(1'b1)) u_ss (
    .clk(clk), .rst_n(rst_n), .d_i(SS_n),
    .level_o(ss_lvl), .rise_o(ss_rise), .fall_o(ss_fall)
  );

  spi_in_synch #(.RST_VAL(1'b0)) u_sclk (
    .clk(clk), .rst_n(rst_n), .d_i(SCLK),
    .level_o(sclk_lvl), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );

  // MOSI needs only its level; same latency as the SCLK level it is sampled against.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mosi_sync_q <= '0;
    else        mosi_sync_q <= {mosi_sync_q[0], MOSI};
  end
  assign mosi_s = mosi_sync_q[1];

  always_comb begin
    ch_sel = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (chnl_q == CH_W'(i)) ch_sel = ch_data[i*RES +: RES];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      rx_q      <= '0;
      tx_q      <= '0;
      cmd_q     <= '0;
      chnl_q    <= '0;
      cmd_vld_q <= 1'b0;
      frm_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      rx_q      <= rx_d;
      tx_q      <= tx_d;
      cmd_q     <= cmd_d;
      chnl_q    <= chnl_d;
      cmd_vld_q <= cmd_vld_d;
      frm_err_q <= frm_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    cmd_d     = cmd_q;
    chnl_d    = chnl_q;
    cmd_vld_d = 1'b0;
    frm_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (ss_fall) begin
          tx_d      = {{(FRM_W-RES){1'b0}}, ch_sel};
          bit_cnt_d = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        // Release takes priority; any SCLK edge in the same clock is dropped.
        if (ss_rise) begin
          if (bit_cnt_q == CNT_FULL) begin
            cmd_d     = rx_q;
            chnl_d    = rx_q[CH_MSB:CH_LSB];
            cmd_vld_d = 1'b1;
          end else begin
            frm_err_d = 1'b1;
          end
          state_d = IDLE;
        end else begin
          if (sclk_rise) begin
            rx_d = {rx_q[FRM_W-2:0], mosi_s};
            if (bit_cnt_q != CNT_MAX) bit_cnt_d = bit_cnt_q + 1'b1;
          end
          // The first falling edge belongs to the bit already on the wire.
          if (sclk_fall && bit_cnt_q != '0) tx_d = {tx_q[FRM_W-2:0], 1'b0};
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign MISO    = ~ss_lvl & tx_q[FRM_W-1];
  assign chnl    = chnl_q;
  assign cmd     = cmd_q;
  assign cmd_vld = cmd_vld_q;
  assign frm_err = frm_err_q;

  logic unused_sclk_lvl;
  assign unused_sclk_lvl = sclk_lvl;
endmodule

// File: tb/tb_a2d_spi_resp.sv
// Directed bench for a2d_spi_resp: drives SPI frames and checks MISO data, cmd/chnl and pulses.
module tb_a2d_spi_resp;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        SS_n = 1'b1;
  logic        SCLK = 1'b0;
  logic        MOSI = 1'b0;
  logic        MISO;
  logic [95:0] ch_data = '0;
  logic [2:0]  chnl;
  logic [15:0] cmd;
  logic        cmd_vld, frm_err;

  int checks = 0;
  int errors = 0;
  int vld_cnt = 0;
  int err_cnt = 0;
  logic prev_vld = 1'b0, prev_err = 1'b0;
  logic [15:0] mi;
  logic [95:0] nd;

  a2d_spi_resp dut (
    .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO),
    .ch_data(ch_data), .chnl(chnl), .cmd(cmd), .cmd_vld(cmd_vld), .frm_err(frm_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (cmd_vld) vld_cnt <= vld_cnt + 1;
    if (frm_err) err_cnt <= err_cnt + 1;
  end

  // Pulses must be exclusive and last exactly one clock.
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      assert (!(cmd_vld && frm_err) && !(cmd_vld && prev_vld) && !(frm_err && prev_err))
        else begin
          errors++;
          $error("FAIL pulse_shape: cmd_vld=%0b frm_err=%0b prev_vld=%0b prev_err=%0b required exclusive 1-clk pulses",
                 cmd_vld, frm_err, prev_vld, prev_err);
        end
    end
    prev_vld = cmd_vld;
    prev_err = frm_err;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One frame; stop_bit>=0 leaves SS_n low with SCLK low before that bit's rise.
  task automatic spi_xfer(input logic [15:0] mo, input int nbits, input int stop_bit,
                          input int chg_bit, input logic [95:0] chg_val,
                          output logic [15:0] miso_cap);
    int idx;
    miso_cap = '0;
    @(negedge clk);
    SS_n = 1'b0;
    MOSI = mo[15];
    wclk(8);
    for (int i = 0; i < nbits; i++) begin
      if (i == stop_bit) break;
      if (i == chg_bit) ch_data = chg_val;
      miso_cap = {miso_cap[14:0], MISO};
      SCLK = 1'b1;
      wclk(8);
      SCLK = 1'b0;
      idx = 15 - (i + 1);
      MOSI = (idx >= 0) ? mo[idx] : 1'b0;
      wclk(8);
    end
    if (stop_bit < 0) begin
      SS_n = 1'b1;
      MOSI = 1'b0;
      wclk(10);
    end
  endtask

  initial begin
    // 1: reset and idle
    wclk(4);
    rst_n = 1'b1;
    wclk(20);
    chk("rst_miso", 32'(MISO), 32'd0);
    chk("rst_chnl", 32'(chnl), 32'd0);
    chk("rst_cmd", 32'(cmd), 32'd0);
    chk("rst_no_pulse", 32'(vld_cnt + err_cnt), 32'd0);

    // 2: pipelined read, ch0 then ch3
    ch_data[11:0]  = 12'hABC;
    ch_data[47:36] = 12'h123;
    spi_xfer(16'h1800, 16, -1, -1, '0, mi);
    chk("f1_miso", 32'(mi), 32'h0ABC);
    chk("f1_chnl", 32'(chnl), 32'd3);
    chk("f1_cmd", 32'(cmd), 32'h1800);
    chk("f1_vld", 32'(vld_cnt), 32'd1);
    spi_xfer(16'h0000, 16, -1, -1, '0, mi);
    chk("f2_miso", 32'(mi), 32'h0123);
    chk("f2_chnl", 32'(chnl), 32'd0);
    chk("f2_vld", 32'(vld_cnt), 32'd2);
    chk("f2_err", 32'(err_cnt), 32'd0);

    // 3: short frame
    spi_xfer(16'h3800, 9, -1, -1, '0, mi);
    chk("short_err", 32'(err_cnt), 32'd1);
    chk("short_cmd", 32'(cmd), 32'h0000);
    chk("short_chnl", 32'(chnl), 32'd0);

    // 4: 17 clocks, then zero clocks
    spi_xfer(16'h3800, 17, -1, -1, '0, mi);
    chk("long_err", 32'(err_cnt), 32'd2);
    chk("long_chnl", 32'(chnl), 32'd0);
    spi_xfer(16'h3800, 0, -1, -1, '0, mi);
    chk("zero_err", 32'(err_cnt), 32'd3);
    chk("zero_vld", 32'(vld_cnt), 32'd2);
    chk("zero_cmd", 32'(cmd), 32'h0000);

    // 5: ch5 changed mid-frame
    spi_xfer(16'h2800, 16, -1, -1, '0, mi);
    chk("sel5_miso", 32'(mi), 32'h0ABC);
    chk("sel5_chnl", 32'(chnl), 32'd5);
    ch_data[71:60] = 12'h555;
    nd = ch_data;
    nd[71:60] = 12'hAAA;
    spi_xfer(16'h2800, 16, -1, 4, nd, mi);
    chk("midchg_miso", 32'(mi), 32'h0555);
    chk("midchg_vld", 32'(vld_cnt), 32'd4);

    // 6: reset at bit 8 of a ch5 (12'hAAA) frame
    spi_xfer(16'h0000, 16, 8, -1, '0, mi);
    chk("prerst_miso", 32'(MISO), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_miso", 32'(MISO), 32'd0);
    chk("rst_mid_chnl", 32'(chnl), 32'd0);
    chk("rst_mid_cmd", 32'(cmd), 32'd0);
    wclk(2);
    SS_n = 1'b1;
    SCLK = 1'b0;
    MOSI = 1'b0;
    wclk(3);
    rst_n = 1'b1;
    wclk(5);
    spi_xfer(16'h1800, 16, -1, -1, '0, mi);
    chk("post_rst_miso", 32'(mi), 32'h0ABC);
    chk("post_rst_chnl", 32'(chnl), 32'd3);
    chk("post_rst_vld", 32'(vld_cnt), 32'd5);
    chk("post_rst_err", 32'(err_cnt), 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL timeout: bench did not complete, required completion before 2ms");
    $fatal(1, "timeout");
  end
endmodule
